// File: rtl/fp_mul_pipe_if.sv
// Operand and result streams of the pipelined IEEE-754 multiplier.
// The slave side is the multiplier; the master side is the operand source and result sink.
interface fp_mul_pipe_if #(
   parameter int unsigned EXP_W  = 5,
   parameter int unsigned FRAC_W = 10
);
   localparam int unsigned W = 1 + EXP_W + FRAC_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [1:0]   in_rm;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic [3:0]   out_flags;

   modport master (
      output in_valid, in_a, in_b, in_rm, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_a, in_b, in_rm, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier: unpack/multiply, normalise, round/pack.
// Whole pipeline freezes while the result is held by downstream backpressure.
module fp_mul_pipe #(
   parameter int unsigned EXP_W  = 5,
   parameter int unsigned FRAC_W = 10
) (
   input logic          clk,
   input logic          rst_n,
   fp_mul_pipe_if.slave io_mul
);
   localparam int unsigned W    = 1 + EXP_W + FRAC_W;
   localparam int unsigned M    = FRAC_W + 1;
   localparam int unsigned P    = 2 * M;
   localparam int unsigned XW   = EXP_W + 3;
   localparam int unsigned LZW  = $clog2(P + 1);
   localparam int unsigned SW   = EXP_W + 2 + FRAC_W;
   localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W - 1){1'b0}}};

   logic w_adv;
   logic r_out_valid;
   logic [W-1:0] r_out_result;
   logic [3:0] r_out_flags;

   assign w_adv             = ~(r_out_valid & ~io_mul.out_ready);
   assign io_mul.in_ready   = w_adv;
   assign io_mul.out_valid  = r_out_valid;
   assign io_mul.out_result = r_out_result;
   assign io_mul.out_flags  = r_out_flags;

   // ---------------- S1: unpack, classify, multiply ----------------
   logic w_sa, w_sb, w_s;
   logic [EXP_W-1:0] w_ea, w_eb, w_xa, w_xb;
   logic [FRAC_W-1:0] w_fa, w_fb;
   logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   logic w_spec;
   logic [W-1:0] w_spec_res;
   logic [3:0] w_spec_flags;
   logic [P-1:0] w_prod;
   logic [EXP_W:0] w_exp_sum;

   assign {w_sa, w_ea, w_fa} = io_mul.in_a;
   assign {w_sb, w_eb, w_fb} = io_mul.in_b;
   assign w_s      = w_sa ^ w_sb;
   assign w_a_nan  = (&w_ea) & (|w_fa);
   assign w_b_nan  = (&w_eb) & (|w_fb);
   assign w_a_snan = w_a_nan & ~w_fa[FRAC_W-1];
   assign w_b_snan = w_b_nan & ~w_fb[FRAC_W-1];
   assign w_a_inf  = (&w_ea) & ~(|w_fa);
   assign w_b_inf  = (&w_eb) & ~(|w_fb);
   assign w_a_zero = ~(|w_ea) & ~(|w_fa);
   assign w_b_zero = ~(|w_eb) & ~(|w_fb);
   // Subnormals carry the minimum-normal exponent with a zero hidden bit
   assign w_xa      = (w_ea == '0) ? EXP_W'(1) : w_ea;
   assign w_xb      = (w_eb == '0) ? EXP_W'(1) : w_eb;
   assign w_prod    = {{M{1'b0}}, |w_ea, w_fa} * {{M{1'b0}}, |w_eb, w_fb};
   assign w_exp_sum = {1'b0, w_xa} + {1'b0, w_xb};

   always_comb begin
      w_spec       = 1'b1;
      w_spec_res   = QNAN;
      w_spec_flags = 4'b0000;
      if (w_a_nan | w_b_nan) begin
         w_spec_flags = {w_a_snan | w_b_snan, 3'b000};
      end else if ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
         w_spec_flags = 4'b1000;
      end else if (w_a_inf | w_b_inf) begin
         w_spec_res = {w_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if (w_a_zero | w_b_zero) begin
         w_spec_res = {w_s, {(W - 1){1'b0}}};
      end else begin
         w_spec = 1'b0;
      end
   end

   logic r_s1_valid, r_s1_sign, r_s1_spec;
   logic [W-1:0] r_s1_spec_res;
   logic [3:0] r_s1_spec_flags;
   logic [1:0] r_s1_rm;
   logic [P-1:0] r_s1_prod;
   logic [EXP_W:0] r_s1_exp_sum;

   // ---------------- S2: normalise ----------------
   logic [LZW-1:0] w_lzc;
   logic [P-1:0] w_norm;
   logic signed [XW-1:0] w_be;

   always_comb begin
      w_lzc = LZW'(P);
      for (int i = 0; i < P; i++) begin
         if (r_s1_prod[i]) w_lzc = LZW'(P - 1 - i);
      end
   end

   assign w_norm = r_s1_prod << w_lzc;
   // Biased exponent of the leading-1 form; may be <= 0 for tiny results
   assign w_be = $signed({2'b00, r_s1_exp_sum}) + $signed(XW'(1)) - $signed(XW'(BIAS))
               - $signed(XW'(w_lzc));

   logic r_s2_valid, r_s2_sign, r_s2_spec;
   logic [W-1:0] r_s2_spec_res;
   logic [3:0] r_s2_spec_flags;
   logic [1:0] r_s2_rm;
   logic [P-1:0] r_s2_norm;
   logic signed [XW-1:0] r_s2_be;

   // ---------------- S3: denormalise, round, pack ----------------
   logic w_tiny, w_lost, w_rbit, w_sticky, w_inexact, w_inc, w_ovf, w_to_inf;
   logic [XW-1:0] w_shamt;
   logic [P-1:0] w_den;
   logic [M-1:0] w_mant;
   logic [EXP_W+1:0] w_exp_base;
   logic [SW-1:0] w_sum;
   logic [W-1:0] w_res;
   logic [3:0] w_flags;

   always_comb begin
      w_tiny  = r_s2_be[XW-1] | (r_s2_be == '0);
      w_shamt = XW'(1) - $unsigned(r_s2_be);
      w_den   = r_s2_norm;
      w_lost  = 1'b0;
      if (w_tiny) begin
         if (w_shamt >= XW'(P)) begin
            w_den  = '0;
            w_lost = |r_s2_norm;
         end else begin
            w_den  = r_s2_norm >> w_shamt;
            w_lost = |(r_s2_norm & ~({P{1'b1}} << w_shamt));
         end
      end
      w_mant    = w_den[P-1 -: M];
      w_rbit    = w_den[P-M-1];
      w_sticky  = (|w_den[P-M-2:0]) | w_lost;
      w_inexact = w_rbit | w_sticky;
      case (r_s2_rm)
         2'd0:    w_inc = w_rbit & (w_sticky | w_mant[0]);
         2'd1:    w_inc = 1'b0;
         2'd2:    w_inc = w_inexact & ~r_s2_sign;
         default: w_inc = w_inexact & r_s2_sign;
      endcase
      // The hidden bit adds one to the exponent field, so a subnormal carrying into it
      // becomes the minimum normal and a full mantissa carry bumps the exponent.
      w_exp_base = w_tiny ? '0 : (r_s2_be[EXP_W+1:0] - (EXP_W + 2)'(1));
      w_sum      = {w_exp_base, {FRAC_W{1'b0}}} + SW'(w_mant) + SW'(w_inc);
      w_ovf      = w_sum[SW-1 -: EXP_W+2] >= (EXP_W + 2)'((1 << EXP_W) - 1);
      w_to_inf   = (r_s2_rm == 2'd0) | ((r_s2_rm == 2'd2) & ~r_s2_sign)
                 | ((r_s2_rm == 2'd3) & r_s2_sign);
      if (w_ovf) begin
         w_res = w_to_inf ? {r_s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                          : {r_s2_sign, {(EXP_W - 1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
      end else begin
         w_res = {r_s2_sign, w_sum[EXP_W+FRAC_W-1:0]};
      end
      w_flags = {1'b0, w_ovf, w_tiny & w_inexact, w_inexact | w_ovf};
      if (r_s2_spec) begin
         w_res   = r_s2_spec_res;
         w_flags = r_s2_spec_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid   <= 1'b0;
         r_s2_valid   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_flags  <= '0;
      end else if (w_adv) begin
         r_s1_valid      <= io_mul.in_valid;
         r_s1_sign       <= w_s;
         r_s1_spec       <= w_spec;
         r_s1_spec_res   <= w_spec_res;
         r_s1_spec_flags <= w_spec_flags;
         r_s1_rm         <= io_mul.in_rm;
         r_s1_prod       <= w_prod;
         r_s1_exp_sum    <= w_exp_sum;

         r_s2_valid      <= r_s1_valid;
         r_s2_sign       <= r_s1_sign;
         r_s2_spec       <= r_s1_spec;
         r_s2_spec_res   <= r_s1_spec_res;
         r_s2_spec_flags <= r_s1_spec_flags;
         r_s2_rm         <= r_s1_rm;
         r_s2_norm       <= w_norm;
         r_s2_be         <= w_be;

         r_out_valid     <= r_s2_valid;
         r_out_result    <= w_res;
         r_out_flags     <= w_flags;
      end
   end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (binary16): directed corner cases, backpressure,
// mid-stream reset and random operands against a value-level rounding model.
module tb_fp_mul_pipe;
   logic clk = 1'b0;
   logic rst_n;

   fp_mul_pipe_if #(.EXP_W(5), .FRAC_W(10)) u_if ();

   fp_mul_pipe #(.EXP_W(5), .FRAC_W(10)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_mul (u_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Exact product m*2^x rounded onto the binary16 grid of quantum 2^q.
   function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] rm);
      int ea, eb, xa, xb, x, msb, top, q, sh, expf;
      longint fa, fb, ma, mb, m, r, rem, half;
      bit s, nan_a, nan_b, sn, inf_a, inf_b, zero_a, zero_b, tiny, inx, inc, up;
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      fa = longint'(a[9:0]);
      fb = longint'(b[9:0]);
      s  = a[15] ^ b[15];
      nan_a  = (ea == 31) && (fa != 0);
      nan_b  = (eb == 31) && (fb != 0);
      sn     = (nan_a && !a[9]) || (nan_b && !b[9]);
      inf_a  = (ea == 31) && (fa == 0);
      inf_b  = (eb == 31) && (fb == 0);
      zero_a = (ea == 0) && (fa == 0);
      zero_b = (eb == 0) && (fb == 0);
      if (nan_a || nan_b) return {sn ? 4'b1000 : 4'b0000, 16'h7E00};
      if ((inf_a && zero_b) || (zero_a && inf_b)) return {4'b1000, 16'h7E00};
      if (inf_a || inf_b) return {4'b0000, s, 15'h7C00};
      if (zero_a || zero_b) return {4'b0000, s, 15'h0000};
      ma = (ea == 0) ? fa : fa + 1024;
      mb = (eb == 0) ? fb : fb + 1024;
      xa = ((ea == 0) ? 1 : ea) - 25;
      xb = ((eb == 0) ? 1 : eb) - 25;
      m  = ma * mb;
      x  = xa + xb;
      msb = 0;
      while ((m >> (msb + 1)) != 0) msb++;
      top  = msb + x;
      tiny = top < -14;
      q    = tiny ? -24 : top - 10;
      if (x >= q) begin
         r    = m << (x - q);
         rem  = 0;
         half = 1;
      end else begin
         sh   = q - x;
         r    = m >> sh;
         rem  = m - (r << sh);
         half = longint'(1) << (sh - 1);
      end
      inx = rem != 0;
      case (rm)
         2'd0:    inc = (rem > half) || ((rem == half) && ((r & 1) != 0));
         2'd1:    inc = 1'b0;
         2'd2:    inc = inx && !s;
         default: inc = inx && s;
      endcase
      r = r + longint'(inc);
      if (r == 2048) begin
         r = 1024;
         q++;
      end
      if (r < 1024) expf = 0;
      else begin
         expf = q + 25;
         r    = r - 1024;
      end
      if (expf >= 31) begin
         up = (rm == 2'd0) || ((rm == 2'd2) && !s) || ((rm == 2'd3) && s);
         return {4'b0101, s, up ? 15'h7C00 : 15'h7BFF};
      end
      return {2'b00, tiny && inx, inx, s, 5'(expf), 10'(r)};
   endfunction

   function automatic logic [15:0] rand_op();
      logic [4:0] e;
      logic [9:0] f;
      f = 10'($urandom);
      case ($urandom % 8)
         0: begin e = 5'd0; f = 10'd0; end
         1: begin e = 5'd31; f = 10'd0; end
         2: begin e = 5'd31; if (f == 0) f = 10'd1; end
         3: e = 5'd0;
         4: e = 5'(1 + $urandom % 6);
         5: e = 5'(24 + $urandom % 7);
         default: e = 5'($urandom % 31);
      endcase
      return {1'($urandom), e, f};
   endfunction

   typedef struct {
      logic [15:0] res;
      logic [3:0]  flg;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   bit   use_fix = 1'b0;
   bit   cur_lat = 1'b0;
   logic [19:0] fix_exp;
   int   rdy_mode = 0;
   bit   prev_stall = 1'b0;
   logic [15:0] held_res;
   logic [3:0]  held_flg;

   // 0: always ready, 1: stalled, 2: random
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       u_if.out_ready = 1'b1;
         1:       u_if.out_ready = 1'b0;
         default: u_if.out_ready = ($urandom % 4) != 0;
      endcase
   end

   always @(negedge clk) begin
      exp_t e;
      logic [19:0] m;
      cyc++;
      if (!rst_n) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("hold_valid", 32'(u_if.out_valid), 32'd1);
            check_eq("hold_result", 32'(u_if.out_result), 32'(held_res));
            check_eq("hold_flags", 32'(u_if.out_flags), 32'(held_flg));
         end
         check_eq("in_ready", 32'(u_if.in_ready), 32'(!(u_if.out_valid && !u_if.out_ready)));
         if (u_if.out_valid && u_if.out_ready) begin
            if (q.size() == 0) begin
               check_eq("spurious_out", 32'(u_if.out_valid), 32'd0);
            end else begin
               e = q.pop_front();
               check_eq("result", 32'(u_if.out_result), 32'(e.res));
               check_eq("flags", 32'(u_if.out_flags), 32'(e.flg));
               if (e.lat) check_eq("latency", 32'(cyc - e.cyc), 32'd3);
            end
         end
         prev_stall = u_if.out_valid && !u_if.out_ready;
         held_res   = u_if.out_result;
         held_flg   = u_if.out_flags;
         if (u_if.in_valid && u_if.in_ready) begin
            m     = use_fix ? fix_exp : ref_mul(u_if.in_a, u_if.in_b, u_if.in_rm);
            e.res = m[15:0];
            e.flg = m[19:16];
            e.cyc = cyc;
            e.lat = cur_lat;
            q.push_back(e);
         end
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm);
      bit ok;
      u_if.in_a     = a;
      u_if.in_b     = b;
      u_if.in_rm    = rm;
      u_if.in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (u_if.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("accept_timeout", 32'(u_if.in_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      u_if.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // {a, b, rm, flags, result}
   logic [53:0] dir_tab[14] = '{
      {16'h3C00, 16'h3C00, 2'd0, 4'b0000, 16'h3C00},
      {16'h7BFF, 16'h4000, 2'd0, 4'b0101, 16'h7C00},
      {16'h7BFF, 16'h4000, 2'd1, 4'b0101, 16'h7BFF},
      {16'hFBFF, 16'h4000, 2'd2, 4'b0101, 16'hFBFF},
      {16'h7BFF, 16'h4000, 2'd3, 4'b0101, 16'h7BFF},
      {16'hFBFF, 16'h4000, 2'd3, 4'b0101, 16'hFC00},
      {16'h7C00, 16'h0000, 2'd0, 4'b1000, 16'h7E00},
      {16'h7D00, 16'h3C00, 2'd0, 4'b1000, 16'h7E00},
      {16'h7E00, 16'h3C00, 2'd0, 4'b0000, 16'h7E00},
      {16'h8000, 16'h3C00, 2'd0, 4'b0000, 16'h8000},
      {16'h0001, 16'h3C00, 2'd0, 4'b0000, 16'h0001},
      {16'h0001, 16'h3800, 2'd0, 4'b0011, 16'h0000},
      {16'h0001, 16'h3800, 2'd2, 4'b0011, 16'h0001},
      {16'h0200, 16'h4400, 2'd0, 4'b0000, 16'h0800}
   };

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [53:0] row;
      rst_n         = 1'b0;
      u_if.in_valid = 1'b0;
      u_if.in_a     = '0;
      u_if.in_b     = '0;
      u_if.in_rm    = 2'd0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_out_valid", 32'(u_if.out_valid), 32'd0);
      check_eq("rst_out_result", 32'(u_if.out_result), 32'd0);
      check_eq("rst_out_flags", 32'(u_if.out_flags), 32'd0);
      check_eq("rst_in_ready", 32'(u_if.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Directed cases back to back: each must come out exactly 3 cycles after acceptance
      use_fix = 1'b1;
      cur_lat = 1'b1;
      for (int i = 0; i < 14; i++) begin
         row     = dir_tab[i];
         fix_exp = row[19:0];
         send(row[53:38], row[37:22], row[21:20]);
      end
      idle(6);
      use_fix = 1'b0;
      cur_lat = 1'b0;

      // Backpressure: downstream stalls for five cycles in the middle of a six-op stream
      fork
         begin
            for (int i = 0; i < 6; i++) send(rand_op(), rand_op(), 2'($urandom));
            idle(1);
         end
         begin
            repeat (4) @(posedge clk);
            rdy_mode = 1;
            @(negedge clk);
            @(negedge clk);
            check_eq("stall_in_ready", 32'(u_if.in_ready), 32'd0);
            check_eq("stall_out_valid", 32'(u_if.out_valid), 32'd1);
            repeat (4) @(posedge clk);
            rdy_mode = 0;
         end
      join
      idle(8);

      // Reset with three operations in flight
      for (int i = 0; i < 3; i++) send(rand_op(), rand_op(), 2'($urandom));
      u_if.in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("midrst_out_valid", 32'(u_if.out_valid), 32'd0);
      check_eq("midrst_in_ready", 32'(u_if.in_ready), 32'd1);
      @(posedge clk);
      #1;
      cur_lat = 1'b1;
      send(16'h4200, 16'hC000, 2'd0);
      cur_lat = 1'b0;
      idle(6);

      // Random operands, random rounding mode, random gaps and random backpressure
      @(posedge clk);
      rdy_mode = 2;
      #1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom % 4 == 0) idle(1 + $urandom % 2);
         send(rand_op(), rand_op(), 2'($urandom));
      end
      u_if.in_valid = 1'b0;
      @(posedge clk);
      rdy_mode = 0;
      idle(20);
      check_eq("drain", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
